// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt controller.
// The index width is derived from the source count.
package irq_pkg;

  localparam int NUM_IRQ  = 4;
  localparam int IRQ_ID_W = $clog2(NUM_IRQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: returns the lowest set request index
// (index 0 wins) together with a valid flag.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N = NUM_IRQ,
  parameter int W = IRQ_ID_W
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller: latches rising edges into a pending
// register, arbitrates unmasked sources and runs a request/service handshake.
module irq_controller
  import irq_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic                mask_we,
  input  logic [NUM_IRQ-1:0]  mask_wdata,
  input  logic                ext_iack,
  input  logic                eret,
  output logic                ext_irq,
  output logic [IRQ_ID_W-1:0] irq_id,
  output logic [NUM_IRQ-1:0]  pending,
  output logic [NUM_IRQ-1:0]  mask,
  output logic                in_service
);

  irq_state_t          state;
  irq_state_t          next_state;
  logic [NUM_IRQ-1:0]  irq_q;
  logic [NUM_IRQ-1:0]  rise;
  logic [NUM_IRQ-1:0]  active;
  logic [NUM_IRQ-1:0]  clr_vec;
  logic [IRQ_ID_W-1:0] enc_idx;
  logic                enc_valid;
  logic [IRQ_ID_W-1:0] next_id;
  logic                grant_clr;

  assign rise   = irq_in & ~irq_q;
  assign active = pending & ~mask;

  irq_prio_enc #(
    .N (NUM_IRQ),
    .W (IRQ_ID_W)
  ) u_prio_enc (
    .req   (active),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_comb begin
    next_state = state;
    next_id    = irq_id;
    grant_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (enc_valid) begin
          next_state = REQ;
          next_id    = enc_idx;
        end
      end
      REQ: begin
        if (ext_iack) begin
          next_state = SERVICE;
          grant_clr  = 1'b1;
        end
      end
      SERVICE: begin
        if (eret) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    clr_vec = '0;
    if (grant_clr) begin
      clr_vec[irq_id] = 1'b1;
    end
  end

  // A fresh edge on the acknowledged source outranks the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      irq_id  <= '0;
      irq_q   <= '0;
      pending <= '0;
      mask    <= '1;
    end else begin
      state   <= next_state;
      irq_id  <= next_id;
      irq_q   <= irq_in;
      pending <= (pending & ~clr_vec) | rise;
      if (mask_we) begin
        mask <= mask_wdata;
      end
    end
  end

  assign ext_irq    = (state == REQ);
  assign in_service = (state == SERVICE);

endmodule

// File: tb/tb_irq_controller.sv
// Directed and randomized bench for irq_controller with a rule-level
// reference model of the pending/mask/grant behaviour.
module tb_irq_controller;

  logic       clk;
  logic       reset;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       ext_iack;
  logic       eret;
  logic       ext_irq;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic [3:0] mask;
  logic       in_service;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = idle, 1 = requesting, 2 = servicing.
  int         m_phase;
  logic [3:0] m_prev;
  logic [3:0] m_pend;
  logic [3:0] m_mask;
  logic [1:0] m_id;

  irq_controller dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ext_iack   (ext_iack),
    .eret       (eret),
    .ext_irq    (ext_irq),
    .irq_id     (irq_id),
    .pending    (pending),
    .mask       (mask),
    .in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelUpdate(input logic rst, input logic [3:0] irq, input logic mwe,
                             input logic [3:0] mwd, input logic ack, input logic er);
    logic [3:0] req;
    bit found;
    if (rst) begin
      m_phase = 0;
      m_prev  = 4'b0000;
      m_pend  = 4'b0000;
      m_mask  = 4'b1111;
      m_id    = 2'd0;
    end else begin
      req = m_pend & ~m_mask;
      if (m_phase == 0) begin
        found = 0;
        for (int i = 0; i < 4; i++) begin
          if (!found && req[i]) begin
            m_id  = 2'(i);
            found = 1;
          end
        end
        if (found) m_phase = 1;
      end else if (m_phase == 1) begin
        if (ack) begin
          m_pend[m_id] = 1'b0;
          m_phase = 2;
        end
      end else begin
        if (er) m_phase = 0;
      end
      m_pend = m_pend | (irq & ~m_prev);
      m_prev = irq;
      if (mwe) m_mask = mwd;
    end
  endtask

  task automatic expectBits(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    expectBits({tag, ".ext_irq"}, {3'b000, ext_irq}, {3'b000, m_phase == 1});
    expectBits({tag, ".in_service"}, {3'b000, in_service}, {3'b000, m_phase == 2});
    expectBits({tag, ".irq_id"}, {2'b00, irq_id}, {2'b00, m_id});
    expectBits({tag, ".pending"}, pending, m_pend);
    expectBits({tag, ".mask"}, mask, m_mask);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic applyStimulus(input string tag, input logic rst, input logic [3:0] irq,
                               input logic mwe, input logic [3:0] mwd,
                               input logic ack, input logic er);
    reset      = rst;
    irq_in     = irq;
    mask_we    = mwe;
    mask_wdata = mwd;
    ext_iack   = ack;
    eret       = er;
    @(posedge clk);
    modelUpdate(rst, irq, mwe, mwd, ack, er);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; ext_iack = 1'b0; eret = 1'b0;
    m_phase = 0; m_prev = '0; m_pend = '0; m_mask = '1; m_id = '0;

    // Reset values
    applyStimulus("rst", 1, 4'b0000, 0, 4'b0000, 0, 0);
    expectBits("rst.pending", pending, 4'b0000);
    expectBits("rst.mask", mask, 4'b1111);
    expectBits("rst.flags", {irq_id, ext_irq, in_service}, 4'b0000);

    // Single source 2: pending next edge, request one edge later
    applyStimulus("s1.mask", 0, 4'b0000, 1, 4'b0000, 0, 0);
    applyStimulus("s1.edge", 0, 4'b0100, 0, 4'b0000, 0, 0);
    expectBits("s1.pending", pending, 4'b0100);
    expectBits("s1.noreq", {3'b000, ext_irq}, 4'b0000);
    applyStimulus("s1.req", 0, 4'b0000, 0, 4'b0000, 0, 0);
    expectBits("s1.ext_irq", {3'b000, ext_irq}, 4'b0001);
    expectBits("s1.irq_id", {2'b00, irq_id}, 4'b0010);

    // Grant is not withdrawn by a higher edge or mask write
    applyStimulus("s4.hold", 0, 4'b0001, 1, 4'b1111, 0, 0);
    expectBits("s4.ext_irq", {3'b000, ext_irq}, 4'b0001);
    expectBits("s4.irq_id", {2'b00, irq_id}, 4'b0010);

    // New edge on source 2 in the acknowledge cycle keeps pending[2]
    applyStimulus("s5.ack", 0, 4'b0100, 0, 4'b0000, 1, 0);
    expectBits("s5.pending", pending, 4'b0101);
    expectBits("s5.in_service", {3'b000, in_service}, 4'b0001);
    applyStimulus("s5.eret", 0, 4'b0000, 0, 4'b0000, 0, 1);

    // Two sources at once, then back-to-back service
    applyStimulus("s2.rst", 1, 4'b0000, 0, 4'b0000, 0, 0);
    applyStimulus("s2.mask", 0, 4'b0000, 1, 4'b0000, 0, 0);
    applyStimulus("s2.edge", 0, 4'b1010, 0, 4'b0000, 0, 0);
    applyStimulus("s2.req", 0, 4'b1010, 0, 4'b0000, 0, 0);
    expectBits("s2.irq_id1", {2'b00, irq_id}, 4'b0001);
    applyStimulus("s2.ack", 0, 4'b0000, 0, 4'b0000, 1, 0);
    expectBits("s2.pending", pending, 4'b1000);
    expectBits("s2.in_service", {3'b000, in_service}, 4'b0001);
    applyStimulus("s2.eret", 0, 4'b0000, 0, 4'b0000, 0, 1);
    expectBits("s2.idle", {2'b00, ext_irq, in_service}, 4'b0000);
    applyStimulus("s2.req3", 0, 4'b0000, 0, 4'b0000, 0, 0);
    expectBits("s2.ext_irq", {3'b000, ext_irq}, 4'b0001);
    expectBits("s2.irq_id3", {2'b00, irq_id}, 4'b0011);

    // Masked source stays silent until unmasked
    applyStimulus("s3.rst", 1, 4'b0000, 0, 4'b0000, 0, 0);
    applyStimulus("s3.mask", 0, 4'b0000, 1, 4'b0001, 0, 0);
    applyStimulus("s3.edge", 0, 4'b0001, 0, 4'b0000, 0, 0);
    expectBits("s3.pending", pending, 4'b0001);
    applyStimulus("s3.wait", 0, 4'b0001, 0, 4'b0000, 0, 0);
    expectBits("s3.masked", {3'b000, ext_irq}, 4'b0000);
    applyStimulus("s3.unmask", 0, 4'b0001, 1, 4'b0000, 0, 0);
    applyStimulus("s3.req", 0, 4'b0001, 0, 4'b0000, 0, 0);
    expectBits("s3.ext_irq", {3'b000, ext_irq}, 4'b0001);
    expectBits("s3.irq_id", {2'b00, irq_id}, 4'b0000);

    // Reset in SERVICE discards the grant; stray ack/eret in IDLE ignored
    applyStimulus("s6.ack", 0, 4'b0000, 0, 4'b0000, 1, 0);
    expectBits("s6.svc", {3'b000, in_service}, 4'b0001);
    applyStimulus("s6.rst", 1, 4'b0100, 0, 4'b0000, 0, 0);
    expectBits("s6.rst.pending", pending, 4'b0000);
    expectBits("s6.rst.mask", mask, 4'b1111);
    expectBits("s6.rst.flags", {irq_id, ext_irq, in_service}, 4'b0000);
    // Line held high through reset release registers as an edge
    applyStimulus("s6.held", 0, 4'b0100, 0, 4'b0000, 0, 0);
    expectBits("s6.held.pending", pending, 4'b0100);
    applyStimulus("s6.iack", 0, 4'b0100, 0, 4'b0000, 1, 0);
    applyStimulus("s6.eret", 0, 4'b0100, 0, 4'b0000, 0, 1);
    expectBits("s6.idle", {2'b00, ext_irq, in_service}, 4'b0000);
    expectBits("s6.idle.pending", pending, 4'b0100);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      applyStimulus("rnd",
                    ($urandom_range(0, 99) == 0),
                    4'($urandom),
                    ($urandom_range(0, 7) == 0),
                    4'($urandom),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
